// File: rtl/sub_bytes_sequencer_if.sv
// Handshake bundle between the round controller / key scheduler and the
// time-shared S-box sequencer: a 128-bit SubBytes channel and a 32-bit
// SubWord channel.
interface sub_bytes_sequencer_if;
    logic         state_valid;
    logic         state_ready;
    logic [127:0] state_in;
    logic         state_out_valid;
    logic         state_out_ready;
    logic [127:0] state_out;

    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_in;
    logic         word_out_valid;
    logic [31:0]  word_out;

    // Requester side: issues operands and consumes results
    modport master (
        output state_valid, state_in, state_out_ready,
        output word_valid, word_in,
        input  state_ready, state_out_valid, state_out,
        input  word_ready, word_out_valid, word_out
    );

    // Sequencer side
    modport slave (
        input  state_valid, state_in, state_out_ready,
        input  word_valid, word_in,
        output state_ready, state_out_valid, state_out,
        output word_ready, word_out_valid, word_out
    );
endinterface

// File: rtl/sub_bytes_sequencer.sv
// Time-shared AES S-box bank. A small bank of LANES combinational S-boxes is
// iterated over a 128-bit state (SubBytes) or a 32-bit word (SubWord), one
// chunk of LANES bytes per cycle. The word requester has fixed priority, but a
// state already in flight is never preempted.

// Combinational AES forward S-box, looked up from a packed constant table
// whose most significant byte is the entry for input 0x00.
module s_box (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry for input x sits at bit offset (255 - x) * 8
    always_comb begin
        dout = SBOX_TABLE[{(8'd255 - din), 3'b000} +: 8];
    end
endmodule

module sub_bytes_sequencer #(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sub_bytes_sequencer_if.slave  bus,
    output logic                  busy
);
    localparam int LANE_BITS      = LANES * 8;
    localparam int STATE_CHUNKS   = 16 / LANES;
    localparam int WORD_CHUNKS    = (4 + LANES - 1) / LANES;
    localparam int CNT_W          = (STATE_CHUNKS > 1) ? $clog2(STATE_CHUNKS) : 1;
    localparam int WORD_LANE_BITS = (LANE_BITS < 32) ? LANE_BITS : 32;

    localparam logic [CNT_W-1:0] STATE_LAST = CNT_W'(STATE_CHUNKS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_CHUNKS - 1);

    localparam logic [127:0] STATE_LANE_MASK = {128{1'b1}} >> (128 - LANE_BITS);
    localparam logic [31:0]  WORD_LANE_MASK  = {32{1'b1}} >> (32 - WORD_LANE_BITS);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_sequencer: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WORD_RUN   = 2'd1,
        STATE_RUN  = 2'd2,
        STATE_HOLD = 2'd3
    } seq_state_t;

    seq_state_t state;
    seq_state_t state_nxt;

    logic             accept_word;
    logic             accept_state;
    logic             word_done;
    logic             state_done;

    logic [CNT_W-1:0] chunk;
    logic [127:0]     operand;
    logic [127:0]     state_res;
    logic [31:0]      word_acc;
    logic [31:0]      word_res;
    logic             word_pulse;

    logic [LANE_BITS-1:0] bank_in;
    logic [LANE_BITS-1:0] bank_out;
    logic [127:0]         state_merged;
    logic [31:0]          word_merged;
    logic [31:0]          word_lane;
    int                   chunk_shift;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic with word priority in IDLE; also flags the accepting
    // cycles and the cycles that write the final chunk of an operation
    always_comb begin
        state_nxt    = state;
        accept_word  = 1'b0;
        accept_state = 1'b0;
        word_done    = 1'b0;
        state_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.word_valid) begin
                    accept_word = 1'b1;
                    state_nxt   = WORD_RUN;
                end else if (bus.state_valid) begin
                    accept_state = 1'b1;
                    state_nxt    = STATE_RUN;
                end
            end
            WORD_RUN: begin
                if (chunk == WORD_LAST) begin
                    word_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STATE_RUN: begin
                if (chunk == STATE_LAST) begin
                    state_done = 1'b1;
                    state_nxt  = STATE_HOLD;
                end
            end
            STATE_HOLD: begin
                if (bus.state_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Readies and status depend only on the FSM, never on the valids
    assign bus.state_ready     = (state == IDLE);
    assign bus.word_ready      = (state == IDLE);
    assign bus.state_out_valid = (state == STATE_HOLD);
    assign busy                = (state != IDLE);
    assign bus.state_out       = state_res;
    assign bus.word_out        = word_res;
    assign bus.word_out_valid  = word_pulse;

    // Select the current chunk of the captured operand and merge the bank
    // result back into the partially built state or word
    always_comb begin
        chunk_shift  = int'(chunk) * LANE_BITS;
        bank_in      = LANE_BITS'(operand >> chunk_shift);
        state_merged = (state_res & ~(STATE_LANE_MASK << chunk_shift))
                     | (128'(bank_out) << chunk_shift);
        word_lane    = 32'(bank_out[WORD_LANE_BITS-1:0]);
        word_merged  = (word_acc & ~(WORD_LANE_MASK << chunk_shift))
                     | (word_lane << chunk_shift);
    end

    genvar lane;
    generate
        for (lane = 0; lane < LANES; lane++) begin : g_bank
            s_box u_sbox (
                .din  (bank_in[lane*8 +: 8]),
                .dout (bank_out[lane*8 +: 8])
            );
        end
    endgenerate

    // Operand capture, chunk counter and result registers; the word pulse
    // is cleared every cycle unless the last word chunk is being written
    always_ff @(posedge clk) begin
        if (rst) begin
            operand    <= '0;
            chunk      <= '0;
            state_res  <= '0;
            word_acc   <= '0;
            word_res   <= '0;
            word_pulse <= 1'b0;
        end else begin
            word_pulse <= 1'b0;
            if (accept_word) begin
                operand <= {96'd0, bus.word_in};
                chunk   <= '0;
            end else if (accept_state) begin
                operand <= bus.state_in;
                chunk   <= '0;
            end else if (state == WORD_RUN) begin
                word_acc <= word_merged;
                if (word_done) begin
                    word_res   <= word_merged;
                    word_pulse <= 1'b1;
                    chunk      <= '0;
                end else begin
                    chunk <= chunk + CNT_W'(1);
                end
            end else if (state == STATE_RUN) begin
                state_res <= state_merged;
                if (state_done) begin
                    chunk <= '0;
                end else begin
                    chunk <= chunk + CNT_W'(1);
                end
            end
        end
    end
endmodule
